// File: rtl/regfile_multiport_pkg.sv
// regfile_multiport_pkg: shared core types for the multi-port register file
package regfile_multiport_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] rv_reg_t;
  typedef struct packed {
    logic       enable;
    logic [4:0] which_register;
    rv_reg_t    value;
  } reg_write_control_t;
  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
endpackage

// File: rtl/regfile_clear_sequencer.sv
// regfile_clear_sequencer: walks every entry writing zero after reset or on request, reporting busy
module regfile_clear_sequencer
  import regfile_multiport_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              clear_req_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);
  rf_state_t         state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == RF_CLEAR) begin
      idx_q <= idx_q + 1'b1;
      if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
        state_q <= RF_READY;
        busy_q  <= 1'b0;
      end
    end else if (clear_req_i) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end
  end
  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = idx_q;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: N-read/M-write register file with registered bypassed reads, stall hold and sequenced clear
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int ZERO_REG  = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          clear_req_i,
  output logic                          busy_o,
  input  logic                          rd_en_i,
  input  logic [NUM_READ*ADDR_W-1:0]    rs_addr_i,
  output logic [NUM_READ*DATA_W-1:0]    rs_val_o,
  input  logic [NUM_WRITE-1:0]          wr_en_i,
  input  logic [NUM_WRITE*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WRITE*DATA_W-1:0]   wr_data_i
);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [ADDR_W-1:0] ra [NUM_READ];
  logic [ADDR_W-1:0] wa [NUM_WRITE];
  logic [DATA_W-1:0] wd [NUM_WRITE];
  logic [NUM_WRITE-1:0] we;
  logic [DATA_W-1:0] rs_val_d [NUM_READ];
  logic [DATA_W-1:0] rs_val_q [NUM_READ];
  logic              busy, clr_we;
  logic [ADDR_W-1:0] clr_addr;
  regfile_clear_sequencer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_seq (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .clear_req_i (clear_req_i),
    .busy_o      (busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );
  assign busy_o = busy;
  for (genvar p = 0; p < NUM_WRITE; p++) begin : g_wp
    assign wa[p] = wr_addr_i[p*ADDR_W +: ADDR_W];
    assign wd[p] = wr_data_i[p*DATA_W +: DATA_W];
    assign we[p] = wr_en_i[p] && !busy && !(ZERO_REG != 0 && wa[p] == '0);
  end
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rp
    assign ra[i] = rs_addr_i[i*ADDR_W +: ADDR_W];
    assign rs_val_o[i*DATA_W +: DATA_W] = rs_val_q[i];
  end
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rs_val_d[i] = (ZERO_REG != 0 && ra[i] == '0) ? '0 : mem_q[ra[i]];
      for (int p = 0; p < NUM_WRITE; p++)
        if (we[p] && wa[p] == ra[i]) rs_val_d[i] = wd[p];
    end
  end
  always_ff @(posedge clock_i) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    for (int p = 0; p < NUM_WRITE; p++)
      if (we[p]) mem_q[wa[p]] <= wd[p];
  end
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < NUM_READ; i++)
      if (!reset_n_i || busy) rs_val_q[i] <= '0;
      else if (rd_en_i) rs_val_q[i] <= rs_val_d[i];
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: random and directed checks of two register files (x0 hardwired and ordinary) against a model
module tb_regfile_multiport;
  localparam int NREG = 32;
  logic clk = 1'b0;
  logic rst_n, clear_req, rd_en;
  logic [4:0]  ra [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [1:0]  we;
  logic [9:0]  rs_addr, wr_addr;
  logic [63:0] wr_data, rsv_z, rsv_n;
  logic        busy_z, busy_n;
  int passed = 0, total = 0;
  bit valid = 0;
  int busy_left = 0;
  logic [31:0] mem [2][NREG];
  logic [31:0] exp_rs [2][2];
  always #5 clk = ~clk;
  assign rs_addr = {ra[1], ra[0]};
  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {wd[1], wd[0]};
  regfile_multiport #(.DATA_W(32), .NUM_REGS(NREG), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(1)) dut_z (
    .clock_i(clk), .reset_n_i(rst_n), .clear_req_i(clear_req), .busy_o(busy_z), .rd_en_i(rd_en),
    .rs_addr_i(rs_addr), .rs_val_o(rsv_z), .wr_en_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data));
  regfile_multiport #(.DATA_W(32), .NUM_REGS(NREG), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(0)) dut_n (
    .clock_i(clk), .reset_n_i(rst_n), .clear_req_i(clear_req), .busy_o(busy_n), .rd_en_i(rd_en),
    .rs_addr_i(rs_addr), .rs_val_o(rsv_n), .wr_en_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data));
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction
  // Model k=0 hardwires x0, k=1 treats x0 as ordinary; clear contents are all-zero once the sequence ends.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_left = NREG;
      valid = 1;
      for (int k = 0; k < 2; k++) for (int i = 0; i < 2; i++) exp_rs[k][i] = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      for (int k = 0; k < 2; k++) for (int i = 0; i < 2; i++) exp_rs[k][i] = 0;
      if (busy_left == 0) for (int k = 0; k < 2; k++) for (int r = 0; r < NREG; r++) mem[k][r] = 0;
    end else begin
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++)
          if (we[p] && !(k == 0 && wa[p] == 0)) mem[k][wa[p]] = wd[p];
      if (rd_en)
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < 2; i++) exp_rs[k][i] = (k == 0 && ra[i] == 0) ? 32'h0 : mem[k][ra[i]];
      if (clear_req) busy_left = NREG;
    end
  end
  always @(negedge clk) begin
    if (valid) begin
      check("busy_z", {31'b0, busy_z}, {31'b0, busy_left > 0});
      check("busy_n", {31'b0, busy_n}, {31'b0, busy_left > 0});
      check("rs0_z", rsv_z[31:0], exp_rs[0][0]);
      check("rs1_z", rsv_z[63:32], exp_rs[0][1]);
      check("rs0_n", rsv_n[31:0], exp_rs[1][0]);
      check("rs1_n", rsv_n[63:32], exp_rs[1][1]);
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    we = 2'b00; clear_req = 1'b0; rd_en = 1'b1;
  endtask
  task automatic count_busy(string name);
    int cnt = 0;
    while (busy_z && cnt < 100) begin tick(); cnt++; end
    check(name, cnt, 32);
  endtask
  initial begin
    rst_n = 1'b0; idle();
    ra[0] = 0; ra[1] = 0; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    tick(); tick();
    rst_n = 1'b1;
    count_busy("busy_after_reset");
    for (int r = 0; r < NREG; r += 2) begin
      ra[0] = 5'(r); ra[1] = 5'(r + 1); tick();
      check("init_rs0", rsv_z[31:0], 0);
      check("init_rs1", rsv_z[63:32], 0);
    end
    we = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[0] = 5; tick();
    check("bypass", rsv_z[31:0], 32'hDEADBEEF);
    we = 2'b11; wa[0] = 7; wd[0] = 1; wa[1] = 7; wd[1] = 2; ra[0] = 7; tick();
    check("conflict_bypass", rsv_z[31:0], 2);
    idle(); ra[1] = 7; tick();
    check("conflict_read", rsv_z[63:32], 2);
    we = 2'b01; wa[0] = 0; wd[0] = 32'hFFFF; ra[0] = 0; tick();
    check("x0_zero_bypass", rsv_z[31:0], 0);
    check("x0_plain_bypass", rsv_n[31:0], 32'h0000FFFF);
    idle(); tick();
    check("x0_zero_read", rsv_z[31:0], 0);
    check("x0_plain_read", rsv_n[31:0], 32'h0000FFFF);
    we = 2'b01; wa[0] = 3; wd[0] = 10; tick();
    idle(); ra[1] = 3; tick();
    check("stall_pre", rsv_z[63:32], 10);
    rd_en = 1'b0; we = 2'b01; wa[0] = 3; wd[0] = 20; tick();
    check("stall_hold", rsv_z[63:32], 10);
    idle(); tick();
    check("stall_release", rsv_z[63:32], 20);
    we = 2'b01; wa[0] = 9; wd[0] = 55; tick();
    idle(); clear_req = 1'b1; tick();
    clear_req = 1'b0; we = 2'b01; wa[0] = 9; wd[0] = 77;
    count_busy("busy_after_clear");
    idle(); ra[0] = 9; tick();
    check("x9_cleared", rsv_z[31:0], 0);
    check("x9_cleared_n", rsv_n[31:0], 0);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    count_busy("busy_after_midclear_reset");
    for (int c = 0; c < 3000; c++) begin
      rd_en = ($urandom_range(0, 3) != 0);
      we = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        wa[p] = 5'($urandom_range(0, 31));
        wd[p] = $urandom;
        ra[p] = ($urandom_range(0, 3) == 0) ? wa[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 7) == 0) wa[1] = wa[0];
      clear_req = ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1; idle(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
